// File: rtl/avg_decimator_pkg.sv
// Shared types for the averager decimation stage.
package avg_decimator_pkg;

  typedef enum logic {
    SETTLING = 1'b0,
    RUNNING  = 1'b1
  } dec_state_e;

endpackage

// File: rtl/avg_decimator_convround.sv
// Convergent (round-half-to-even) width reduction from IW to OW bits with
// positive saturation; purely combinational.
module convround #(
  parameter int IW = 16,
  parameter int OW = 12
) (
  input  logic [IW-1:0] i_val,
  output logic [OW-1:0] o_val
);

  localparam int FW = IW - OW;
  localparam logic [FW-1:0] HALF   = FW'(1) << (FW - 1);
  localparam logic [OW-1:0] MAXPOS = {1'b0, {(OW-1){1'b1}}};

  logic [OW-1:0] t;
  logic [FW-1:0] f;
  logic          round_up;

  always_comb begin
    t        = i_val[IW-1:FW];
    f        = i_val[FW-1:0];
    round_up = (f > HALF) || ((f == HALF) && t[0]);
    // Only the max-positive value can overflow on round-up; negatives move toward zero.
    if (round_up && (t != MAXPOS)) begin
      o_val = t + OW'(1);
    end else begin
      o_val = t;
    end
  end

endmodule

// File: rtl/avg_decimator.sv
// Decimates the averager output by 2**LGDECIM, rounds it to OW bits and
// suppresses the first SETTLE decimated outputs after reset or restart.
module avg_decimator
  import avg_decimator_pkg::*;
#(
  parameter int IW      = 16,
  parameter int OW      = 12,
  parameter int LGDECIM = 4,
  parameter int SETTLE  = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_val,
  input  logic          i_restart,
  output logic          o_ce,
  output logic [OW-1:0] o_val,
  output logic          o_settled
);

  localparam int PW = (LGDECIM > 0) ? LGDECIM : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'((1 << LGDECIM) - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [SW-1:0] SETTLE_FULL  = SW'(SETTLE);
  localparam dec_state_e    INIT_STATE   = (SETTLE == 0) ? RUNNING : SETTLING;
  localparam logic          INIT_SETTLED = (SETTLE == 0);

  dec_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          o_ce_q, o_ce_d;
  logic [OW-1:0] o_val_q, o_val_d;
  logic          settled_q, settled_d;
  logic [OW-1:0] rounded;
  logic          block_done;

  convround #(
    .IW(IW),
    .OW(OW)
  ) u_round (
    .i_val(i_val),
    .o_val(rounded)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    settle_d   = settle_q;
    o_ce_d     = 1'b0;
    o_val_d    = o_val_q;
    settled_d  = settled_q;
    block_done = i_ce && (phase_q == PHASE_LAST);
    if (i_restart) begin
      // Restart beats a coincident strobe: the sample neither counts nor updates o_val.
      state_d   = INIT_STATE;
      phase_d   = '0;
      settle_d  = '0;
      settled_d = INIT_SETTLED;
    end else if (i_ce) begin
      phase_d = block_done ? '0 : phase_q + PW'(1);
      if (block_done) begin
        o_val_d = rounded;
        case (state_q)
          SETTLING: begin
            if (settle_q == SETTLE_LAST) begin
              state_d   = RUNNING;
              settle_d  = SETTLE_FULL;
              settled_d = 1'b1;
            end else begin
              settle_d = settle_q + SW'(1);
            end
          end
          RUNNING: o_ce_d = 1'b1;
          default: state_d = INIT_STATE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= INIT_STATE;
      phase_q   <= '0;
      settle_q  <= '0;
      o_ce_q    <= 1'b0;
      o_val_q   <= '0;
      settled_q <= INIT_SETTLED;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      settle_q  <= settle_d;
      o_ce_q    <= o_ce_d;
      o_val_q   <= o_val_d;
      settled_q <= settled_d;
    end
  end

  assign o_ce      = o_ce_q;
  assign o_val     = o_val_q;
  assign o_settled = settled_q;

endmodule

// File: tb/tb_avg_decimator.sv
// Directed bench for avg_decimator: three parameterisations share one stimulus stream.
module tb_avg_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] val;
  logic        restart;

  logic        o_ce_a, o_ce_b, o_ce_c;
  logic [11:0] o_val_a, o_val_b, o_val_c;
  logic        o_settled_a, o_settled_b, o_settled_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avg_decimator #(.IW(16), .OW(12), .LGDECIM(4), .SETTLE(16)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_val(val), .i_restart(restart),
    .o_ce(o_ce_a), .o_val(o_val_a), .o_settled(o_settled_a)
  );

  avg_decimator #(.IW(16), .OW(12), .LGDECIM(4), .SETTLE(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_val(val), .i_restart(restart),
    .o_ce(o_ce_b), .o_val(o_val_b), .o_settled(o_settled_b)
  );

  avg_decimator #(.IW(16), .OW(12), .LGDECIM(0), .SETTLE(0)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_val(val), .i_restart(restart),
    .o_ce(o_ce_c), .o_val(o_val_c), .o_settled(o_settled_c)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic c, input logic [15:0] v, input logic r);
    ce = c; val = v; restart = r;
    @(posedge clk); #1;
  endtask

  initial begin
    int ph;
    int ce_n;
    int oce_n;
    logic prev_oce;
    logic consec;
    logic exp_oce;
    logic c;

    rst = 1'b1; ce = 1'b0; val = '0; restart = 1'b0;
    #2;
    chk("rst_a_ce", o_ce_a, 0);
    chk("rst_a_val", o_val_a, 0);
    chk("rst_a_settled", o_settled_a, 0);
    chk("rst_b_settled", o_settled_b, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: SETTLE=0, i_ce every clock, o_ce once per 16 strobes.
    for (int k = 1; k <= 32; k++) begin
      if (k == 16)      step(1'b1, 16'h1238, 1'b0);
      else if (k == 32) step(1'b1, 16'h8010, 1'b0);
      else              step(1'b1, 16'h0000, 1'b0);
      chk("t1_oce", o_ce_b, (k % 16 == 0) ? 16'd1 : 16'd0);
      chk("t1_settled", o_settled_b, 1);
      if (k == 16) chk("t1_val16", o_val_b, 16'h0124);
      if (k == 17) chk("t1_val17_hold", o_val_b, 16'h0124);
      if (k == 32) chk("t1_val32", o_val_b, 16'h0801);
    end

    // Test 2: rounding through the undecimated instance.
    step(1'b1, 16'h0018, 1'b0); chk("t2_0018_ce", o_ce_c, 1); chk("t2_0018", o_val_c, 16'h0002);
    step(1'b1, 16'h0028, 1'b0); chk("t2_0028", o_val_c, 16'h0002);
    step(1'b1, 16'h0029, 1'b0); chk("t2_0029", o_val_c, 16'h0003);
    step(1'b1, 16'hFFF8, 1'b0); chk("t2_FFF8", o_val_c, 16'h0000);
    step(1'b1, 16'hFFE8, 1'b0); chk("t2_FFE8", o_val_c, 16'h0FFE);
    step(1'b1, 16'h7FF8, 1'b0); chk("t2_7FF8", o_val_c, 16'h07FF);
    step(1'b1, 16'h8000, 1'b0); chk("t2_8000", o_val_c, 16'h0800);
    step(1'b0, 16'h0029, 1'b0); chk("t2_idle_ce", o_ce_c, 0); chk("t2_idle_hold", o_val_c, 16'h0800);

    // Test 3: settling with defaults.
    rst = 1'b1; #1; rst = 1'b0;
    for (int k = 1; k <= 271; k++) begin
      step(1'b1, 16'h0018, 1'b0);
      chk("t3_no_oce", o_ce_a, 0);
      chk("t3_settled", o_settled_a, (k >= 256) ? 16'd1 : 16'd0);
      if (k == 16) chk("t3_val_in_settling", o_val_a, 16'h0002);
    end
    step(1'b1, 16'h0029, 1'b0);
    chk("t3_first_oce", o_ce_a, 1);
    chk("t3_first_val", o_val_a, 16'h0003);
    step(1'b0, 16'h0000, 1'b0);
    chk("t3_oce_one_cycle", o_ce_a, 0);

    // Test 5: restart together with i_ce at phase 9 while running.
    for (int k = 1; k <= 9; k++) step(1'b1, 16'h0028, 1'b0);
    step(1'b1, 16'h7FF8, 1'b1);
    chk("t5_settled_drop", o_settled_a, 0);
    chk("t5_no_oce", o_ce_a, 0);
    chk("t5_val_held", o_val_a, 16'h0003);
    for (int k = 1; k <= 256; k++) begin
      step(1'b1, 16'h0028, 1'b0);
      chk("t5_resettle", o_settled_a, (k >= 256) ? 16'd1 : 16'd0);
      chk("t5_no_oce_settling", o_ce_a, 0);
      if (k == 15) chk("t5_val_held15", o_val_a, 16'h0003);
    end
    chk("t5_val_after", o_val_a, 16'h0002);

    // Test 4: gapped strobes at roughly 30% duty while running (phase 0 here).
    ph = 0; ce_n = 0; oce_n = 0; prev_oce = 1'b0; consec = 1'b0;
    for (int k = 0; k < 600; k++) begin
      c = ($urandom_range(0, 99) < 30);
      exp_oce = c && (ph == 15);
      if (c) begin
        ce_n++;
        ph = (ph + 1) % 16;
      end
      step(c, 16'($urandom), 1'b0);
      chk("t4_oce", o_ce_a, {15'd0, exp_oce});
      if (o_ce_a) oce_n++;
      if (o_ce_a && prev_oce) consec = 1'b1;
      prev_oce = o_ce_a;
    end
    step(1'b0, 16'h0000, 1'b0);
    if (o_ce_a) oce_n++;
    if (o_ce_a && prev_oce) consec = 1'b1;
    chk("t4_count", 16'(oce_n), 16'(ce_n / 16));
    chk("t4_no_back_to_back", {15'd0, consec}, 0);

    // Test 6: asynchronous reset between edges, mid-block.
    for (int k = 1; k <= 5; k++) step(1'b1, 16'h0100, 1'b0);
    chk("t6_pre_val_c", o_val_c, 16'h0010);
    chk("t6_pre_ce_c", o_ce_c, 1);
    chk("t6_pre_settled_a", o_settled_a, 1);
    #2; rst = 1'b1; #1;
    chk("t6_async_ce_c", o_ce_c, 0);
    chk("t6_async_val_c", o_val_c, 0);
    chk("t6_async_settled_a", o_settled_a, 0);
    chk("t6_async_settled_b", o_settled_b, 1);
    chk("t6_async_val_b", o_val_b, 0);
    #1; rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 16'h0200, 1'b0);
      chk("t6_b_oce", o_ce_b, (k == 16) ? 16'd1 : 16'd0);
      chk("t6_a_oce", o_ce_a, 0);
    end
    chk("t6_b_val", o_val_b, 16'h0020);
    chk("t6_a_settled", o_settled_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
